axi_lite_cfg_master: RTL and testbench
======================================

# axi_lite_cfg_master

AXI4-Lite initiator that converts single-beat commands from a simple valid/ready command port into AXI4-Lite write or read transactions. It returns each transaction's result on a valid/ready response port. It sits between the control sequencer (or the bench-side stimulus) and `axi_lite_mm2dds_mod_registers`, so the DDS modulator configuration registers (0x00–0x14) can be programmed from RTL. One transaction is outstanding at a time, and a bounded timeout prevents lockup.

## Interface
- `ADDR_W`, 32, width of command and AXI addresses
- `TIMEOUT`, 1024, cycles to wait for any AXI handshake before aborting; 0 disables the timeout
- `clk_i`  in  1  clock
- `resetn_i`  in  1  reset; asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `cmd_valid_i`  in  1  command present
- `cmd_ready_o`  out  1  command accepted when high together with `cmd_valid_i`
- `cmd_write_i`  in  1  1 = write, 0 = read
- `cmd_addr_i`  in  ADDR_W  byte address
- `cmd_wdata_i`  in  32  write data
- `cmd_wstrb_i`  in  4  write strobes
- `rsp_valid_o`  out  1  response present
- `rsp_ready_i`  in  1  response consumed
- `rsp_write_o`  out  1  echo of the command type
- `rsp_rdata_o`  out  32  read data; 0 for writes
- `rsp_resp_o`  out  2  BRESP/RRESP, or 2'b10 on timeout
- `rsp_timeout_o`  out  1  the response was produced by a timeout
- `M_AXI_AWADDR/AWVALID/AWREADY`, `M_AXI_WDATA/WSTRB/WVALID/WREADY`, `M_AXI_BRESP/BVALID/BREADY`, `M_AXI_ARADDR/ARVALID/ARREADY`, `M_AXI_RDATA/RRESP/RVALID/RREADY`
  - Standard AXI4-Lite master directions and widths; addresses are ADDR_W wide, data is 32 bits.

## Operation
- **States:** IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- **IDLE:**
  - `cmd_ready_o` = 1.
  - On handshake, latch addr/data/strb/type. Go to WR_REQ if write, RD_REQ if read.
- **WR_REQ:**
  - AWVALID and WVALID are asserted together.
  - Each channel deasserts independently on the edge where its READY is sampled high. Internal flags `aw_done` and `w_done` track completion.
  - When both channels are done, go to WR_RESP.
- **WR_RESP:**
  - BREADY = 1.
  - On BVALID, capture BRESP and go to RSP.
- **RD_REQ:**
  - ARVALID = 1.
  - On ARREADY, go to RD_RESP.
- **RD_RESP:**
  - RREADY = 1.
  - On RVALID, capture RDATA/RRESP and go to RSP.
- **RSP:**
  - `rsp_valid_o` = 1. The response fields are held stable until `rsp_ready_i`, then return to IDLE.
- **Address and data stability:** AWADDR, ARADDR, WDATA and WSTRB are registered and stable while the corresponding VALID is high. VALID is never withdrawn before READY, except on timeout.
- **Timeout counter:**
  - Cleared on command accept and on each AXI handshake.
  - Increments in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - On reaching TIMEOUT (when TIMEOUT ≠ 0):
    - drop all VALIDs;
    - go to RSP with `rsp_resp_o` = 2'b10, `rsp_timeout_o` = 1, `rsp_rdata_o` = 0.
- **Late responses:** In IDLE and RSP, BREADY and RREADY are held at 1 to drain late BVALID/RVALID from a timed-out transaction. Drained beats are discarded and never produce a response.
  - Exception: BREADY/RREADY are not asserted in the same cycle a new command is accepted.
- **Ignored inputs:** Command fields are ignored outside the IDLE handshake.

## Timing
- **Reset values:** all VALIDs = 0; `cmd_ready_o` = 0 during reset and 1 from the first cycle after release; BREADY = 0, RREADY = 0; `rsp_valid_o` = 0; all data/address/response outputs = 0.
- **Reset mid-transaction:** all outputs return to the reset values immediately (asynchronously). The state returns to IDLE with no response issued.
- **Write latency (zero-wait slave):**
  - edge 0: command accept;
  - cycle 1: AW/W VALID;
  - cycle 2: BREADY; a BVALID present in cycle 2 is captured;
  - cycle 3: `rsp_valid_o`.
- **Read latency (zero-wait slave):** the same sequence applies, giving `rsp_valid_o` in cycle 3.
- **Back-to-back commands:**
  - `rsp_ready_i` in cycle N returns the block to IDLE in cycle N+1.
  - The next command can be accepted at the end of cycle N+1.
  - Maximum throughput is one transaction per 4 cycles.
- **Simultaneous AWREADY and WREADY:** both channels complete on the same edge, and the next state is WR_RESP.
- **BVALID while in WR_REQ:** ignored until WR_RESP, because BREADY stays low in WR_REQ. The slave holds BVALID.
- **Timeout boundary:** with TIMEOUT = T, timeout fires on the T-th consecutive wait cycle without a handshake. A handshake in that same cycle wins over the timeout.

## Test plan
- **Write:** cmd write addr 0x0C, data 0x0000_1234, strb 0xF to the register slave → AWADDR = 0x0C and WDATA = 0x1234 in cycle 1; response `rsp_resp_o` = 0, `rsp_timeout_o` = 0; slave `config_reg_3` = 0x1234.
- **Read-back:** cmd read addr 0x0C after the write above → ARADDR = 0x0C; `rsp_rdata_o` = 0x0000_1234, `rsp_resp_o` = 0, `rsp_write_o` = 0.
- **Skewed write handshakes:** stub slave with AWREADY delayed 3 cycles and WREADY immediate, write 0x04 = 0x2 → WVALID drops after cycle 1; AWVALID is held with a stable address for 4 cycles; exactly one B handshake; one response.
- **Timeout:** TIMEOUT = 16, slave never asserts ARREADY → ARVALID drops after 16 cycles; response `rsp_resp_o` = 2'b10, `rsp_timeout_o` = 1, `rsp_rdata_o` = 0. A later stray RVALID is drained with no extra response.
- **Back-to-back programming:** write sequence 0x04 = 2, 0x08 = 0x1F40_9C40, 0x00 = 3 issued back-to-back with `rsp_ready_i` = 1 → three responses in order; all three registers updated; at most one transaction outstanding.
- **Reset mid-transaction:** assert `resetn_i` low while in WR_RESP → all VALIDs and `rsp_valid_o` go to 0 immediately; after release the block is in IDLE with `cmd_ready_o` = 1, and the next write completes normally.

Source files
------------

// File: rtl/axi_lite_cfg_master.sv
// rtl/axi_lite_cfg_master.sv - single-outstanding AXI4-Lite initiator for register programming
// Turns one valid/ready command into one AXI4-Lite write or read and returns a response.
module axi_lite_cfg_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_wdata_i,
    input  logic [3:0]        cmd_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_write_o,
    output logic [31:0]       rsp_rdata_o,
    output logic [1:0]        rsp_resp_o,
    output logic              rsp_timeout_o,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_RESP,
        S_RSP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_alive;
    logic              r_aw_done;
    logic              r_w_done;
    logic [31:0]       r_wait_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_rsp_write;
    logic [31:0]       r_rsp_rdata;
    logic [1:0]        r_rsp_resp;
    logic              r_rsp_timeout;

    logic w_accept;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_hs_any;
    logic w_waiting;
    logic w_timeout;

    // Handshakes are derived from state rather than from the VALID/READY outputs to keep the comb logic acyclic.
    assign w_accept  = r_alive && (r_state == S_IDLE) && cmd_valid_i;
    assign w_aw_hs   = (r_state == S_WR_REQ) && !r_aw_done && M_AXI_AWREADY;
    assign w_w_hs    = (r_state == S_WR_REQ) && !r_w_done && M_AXI_WREADY;
    assign w_b_hs    = (r_state == S_WR_RESP) && M_AXI_BVALID;
    assign w_ar_hs   = (r_state == S_RD_REQ) && M_AXI_ARREADY;
    assign w_r_hs    = (r_state == S_RD_RESP) && M_AXI_RVALID;
    assign w_hs_any  = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;
    assign w_waiting = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                       (r_state == S_RD_REQ) || (r_state == S_RD_RESP);
    assign w_timeout = (TIMEOUT != 0) && w_waiting && !w_hs_any &&
                       (r_wait_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        cmd_ready_o   = 1'b0;
        rsp_valid_o   = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready_o  = r_alive;
                // Drain late beats, but never in the cycle a new command is taken.
                M_AXI_BREADY = r_alive && !cmd_valid_i;
                M_AXI_RREADY = r_alive && !cmd_valid_i;
                if (w_accept) begin
                    w_state_nxt = cmd_write_i ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                M_AXI_AWVALID = !r_aw_done;
                M_AXI_WVALID  = !r_w_done;
                if (w_timeout) begin
                    w_state_nxt = S_RSP;
                end else if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (w_b_hs || w_timeout) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RD_REQ: begin
                M_AXI_ARVALID = 1'b1;
                if (w_ar_hs) begin
                    w_state_nxt = S_RD_RESP;
                end else if (w_timeout) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RD_RESP: begin
                M_AXI_RREADY = 1'b1;
                if (w_r_hs || w_timeout) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid_o  = 1'b1;
                M_AXI_BREADY = 1'b1;
                M_AXI_RREADY = 1'b1;
                if (rsp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_alive       <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_wait_cnt    <= 32'd0;
            r_addr        <= '0;
            r_wdata       <= 32'd0;
            r_wstrb       <= 4'd0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_accept) begin
                r_addr      <= cmd_addr_i;
                r_wdata     <= cmd_wdata_i;
                r_wstrb     <= cmd_wstrb_i;
                r_rsp_write <= cmd_write_i;
                r_aw_done   <= 1'b0;
                r_w_done    <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if (w_accept || w_hs_any) begin
                r_wait_cnt <= 32'd0;
            end else if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
            if (w_timeout) begin
                r_rsp_resp    <= 2'b10;
                r_rsp_rdata   <= 32'd0;
                r_rsp_timeout <= 1'b1;
            end else if (w_b_hs) begin
                r_rsp_resp    <= M_AXI_BRESP;
                r_rsp_rdata   <= 32'd0;
                r_rsp_timeout <= 1'b0;
            end else if (w_r_hs) begin
                r_rsp_resp    <= M_AXI_RRESP;
                r_rsp_rdata   <= M_AXI_RDATA;
                r_rsp_timeout <= 1'b0;
            end
        end
    end

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign rsp_write_o   = r_rsp_write;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_resp_o    = r_rsp_resp;
    assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// tb/tb_axi_lite_cfg_master.sv - directed bench for axi_lite_cfg_master with a behavioural register slave
module tb_axi_lite_cfg_master;

    logic        clk_i = 1'b0;
    logic        resetn_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [31:0] cmd_addr_i = 32'd0;
    logic [31:0] cmd_wdata_i = 32'd0;
    logic [3:0]  cmd_wstrb_i = 4'd0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic        rsp_write_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_resp_o;
    logic        rsp_timeout_o;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY = 1'b0;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00;
    logic        M_AXI_BVALID = 1'b0;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b0;
    logic [31:0] M_AXI_RDATA = 32'd0;
    logic [1:0]  M_AXI_RRESP = 2'b00;
    logic        M_AXI_RVALID = 1'b0;
    logic        M_AXI_RREADY;

    axi_lite_cfg_master #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o), .rsp_timeout_o(rsp_timeout_o),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave controls, written only by the test sequence
    int   aw_lat = 0;
    logic ar_never = 1'b0;
    logic b_stall = 1'b0;
    logic stray_req = 1'b0;

    // Slave state, written only by the monitor
    logic [31:0] regs [8] = '{default: 32'd0};
    logic [31:0] aw_log [$];
    int          cyc = 0, aw_cyc = 0, acc_n = 0, rsp_n = 0, b_n = 0, r_n = 0, max_out = 0;
    logic        aw_have = 1'b0, w_have = 1'b0, b_pending = 1'b0, r_pending = 1'b0;
    logic [31:0] s_awaddr = 32'd0, s_wdata = 32'd0, r_data = 32'd0;
    logic [3:0]  s_wstrb = 4'd0;

    always @(posedge clk_i) begin
        cyc++;
        if (!resetn_i) begin
            aw_have = 1'b0; w_have = 1'b0; b_pending = 1'b0; r_pending = 1'b0; aw_cyc = 0;
        end else begin
            if (cmd_valid_i && cmd_ready_o) acc_n++;
            if (rsp_valid_o && rsp_ready_i) rsp_n++;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_have = 1'b1; s_awaddr = M_AXI_AWADDR; aw_log.push_back(M_AXI_AWADDR); aw_cyc = 0;
            end else if (M_AXI_AWVALID) begin
                aw_cyc++;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_have = 1'b1; s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin b_n++; b_pending = 1'b0; end
            if (aw_have && w_have) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) regs[s_awaddr[4:2]][8*b +: 8] = s_wdata[8*b +: 8];
                b_pending = 1'b1; aw_have = 1'b0; w_have = 1'b0;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin r_n++; r_pending = 1'b0; end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin r_pending = 1'b1; r_data = regs[M_AXI_ARADDR[4:2]]; end
            if (stray_req) begin r_pending = 1'b1; r_data = 32'hDEAD_BEEF; end
            if (acc_n - rsp_n > max_out) max_out = acc_n - rsp_n;
        end
    end

    always @(negedge clk_i) begin
        M_AXI_AWREADY = M_AXI_AWVALID && (aw_cyc >= aw_lat);
        M_AXI_WREADY  = M_AXI_WVALID;
        M_AXI_BVALID  = b_pending && !b_stall;
        M_AXI_BRESP   = 2'b00;
        M_AXI_ARREADY = M_AXI_ARVALID && !ar_never;
        M_AXI_RVALID  = r_pending;
        M_AXI_RDATA   = r_data;
        M_AXI_RRESP   = 2'b00;
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = data; cmd_wstrb_i = 4'hF;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if ({cmd_ready_o, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid_o} !== 7'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 0000000", {cmd_ready_o, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid_o}); end
        n_cmp++; if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB, rsp_rdata_o, rsp_resp_o, rsp_timeout_o, rsp_write_o} !== '0) begin n_bad++; $display("FAIL reset_data: got %h %h %h want all 0", M_AXI_AWADDR, M_AXI_WDATA, rsp_rdata_o); end
        @(negedge clk_i); resetn_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if ({cmd_ready_o, M_AXI_BREADY, M_AXI_RREADY} !== 3'b111) begin n_bad++; $display("FAIL reset_release: got %b want 111", {cmd_ready_o, M_AXI_BREADY, M_AXI_RREADY}); end
    endtask

    task automatic test_write();
        issue(1'b1, 32'h0C, 32'h0000_1234);
        n_cmp++; if (cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL wr_cmd_ready: got %b want 1", cmd_ready_o); end
        @(negedge clk_i); cmd_valid_i = 1'b0; cmd_addr_i = 32'hFFFF_FFF0; cmd_wdata_i = 32'hFFFF_FFFF;
        n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, cmd_ready_o} !== 4'b1100) begin n_bad++; $display("FAIL wr_c1_valids: got %b want 1100", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, cmd_ready_o}); end
        n_cmp++; if ({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB} !== {32'h0C, 32'h1234, 4'hF}) begin n_bad++; $display("FAIL wr_c1_payload: got %h %h %h want 0000000c 00001234 f", M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB); end
        @(negedge clk_i);
        n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rsp_valid_o} !== 4'b0010) begin n_bad++; $display("FAIL wr_c2: got %b want 0010", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rsp_valid_o}); end
        @(negedge clk_i);
        n_cmp++; if ({rsp_valid_o, rsp_write_o, rsp_resp_o, rsp_timeout_o} !== 5'b11000) begin n_bad++; $display("FAIL wr_c3_rsp: got %b want 11000", {rsp_valid_o, rsp_write_o, rsp_resp_o, rsp_timeout_o}); end
        n_cmp++; if (rsp_rdata_o !== 32'd0) begin n_bad++; $display("FAIL wr_rdata: got %h want 0", rsp_rdata_o); end
        rsp_ready_i = 1'b1;
        @(negedge clk_i); rsp_ready_i = 1'b0;
        n_cmp++; if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin n_bad++; $display("FAIL wr_idle: got %b want 01", {rsp_valid_o, cmd_ready_o}); end
        n_cmp++; if (regs[3] !== 32'h1234) begin n_bad++; $display("FAIL wr_reg3: got %h want 00001234", regs[3]); end
    endtask

    task automatic test_readback();
        issue(1'b0, 32'h0C, 32'h0);
        @(negedge clk_i); cmd_valid_i = 1'b0;
        n_cmp++; if ({M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_ARADDR} !== {2'b10, 32'h0C}) begin n_bad++; $display("FAIL rd_c1: got %b %h want 10 0000000c", {M_AXI_ARVALID, M_AXI_AWVALID}, M_AXI_ARADDR); end
        @(negedge clk_i);
        n_cmp++; if ({M_AXI_ARVALID, M_AXI_RREADY} !== 2'b01) begin n_bad++; $display("FAIL rd_c2: got %b want 01", {M_AXI_ARVALID, M_AXI_RREADY}); end
        @(negedge clk_i);
        n_cmp++; if ({rsp_valid_o, rsp_write_o, rsp_resp_o, rsp_timeout_o} !== 5'b10000) begin n_bad++; $display("FAIL rd_rsp: got %b want 10000", {rsp_valid_o, rsp_write_o, rsp_resp_o, rsp_timeout_o}); end
        n_cmp++; if (rsp_rdata_o !== 32'h0000_1234) begin n_bad++; $display("FAIL rd_rdata: got %h want 00001234", rsp_rdata_o); end
        rsp_ready_i = 1'b1;
        @(negedge clk_i); rsp_ready_i = 1'b0;
    endtask

    task automatic test_skewed_write();
        int   b0, r0;
        logic [2:0] exp;
        b0 = b_n; r0 = rsp_n; aw_lat = 3;
        issue(1'b1, 32'h04, 32'h2);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_i); cmd_valid_i = 1'b0;
            exp = {c <= 4, c == 1, c == 6};
            n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID, rsp_valid_o} !== exp) begin n_bad++; $display("FAIL skew_c%0d: got %b want %b", c, {M_AXI_AWVALID, M_AXI_WVALID, rsp_valid_o}, exp); end
            if (c <= 4) begin
                n_cmp++; if (M_AXI_AWADDR !== 32'h04) begin n_bad++; $display("FAIL skew_awaddr_c%0d: got %h want 00000004", c, M_AXI_AWADDR); end
            end
            if (c == 6) rsp_ready_i = 1'b1;
        end
        @(negedge clk_i); rsp_ready_i = 1'b0; aw_lat = 0;
        repeat (2) @(negedge clk_i);
        n_cmp++; if ({b_n - b0, rsp_n - r0} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL skew_counts: got b=%0d rsp=%0d want 1 1", b_n - b0, rsp_n - r0); end
        n_cmp++; if (regs[1] !== 32'h2) begin n_bad++; $display("FAIL skew_reg1: got %h want 00000002", regs[1]); end
    endtask

    task automatic test_timeout();
        int r0, rh0;
        ar_never = 1'b1;
        issue(1'b0, 32'h10, 32'h0);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk_i); cmd_valid_i = 1'b0;
            n_cmp++; if ({M_AXI_ARVALID, rsp_valid_o} !== {c <= 16, c == 17}) begin n_bad++; $display("FAIL to_c%0d: got %b want %b", c, {M_AXI_ARVALID, rsp_valid_o}, {c <= 16, c == 17}); end
        end
        n_cmp++; if ({rsp_resp_o, rsp_timeout_o, rsp_write_o, rsp_rdata_o} !== {2'b10, 1'b1, 1'b0, 32'd0}) begin n_bad++; $display("FAIL to_rsp: got %b %b %b %h want 10 1 0 0", rsp_resp_o, rsp_timeout_o, rsp_write_o, rsp_rdata_o); end
        rsp_ready_i = 1'b1;
        @(negedge clk_i); rsp_ready_i = 1'b0; ar_never = 1'b0;
        r0 = rsp_n; rh0 = r_n; stray_req = 1'b1;
        @(negedge clk_i); stray_req = 1'b0;
        repeat (3) @(negedge clk_i);
        n_cmp++; if ({rsp_valid_o, cmd_ready_o, M_AXI_RVALID} !== 3'b010) begin n_bad++; $display("FAIL to_drain_state: got %b want 010", {rsp_valid_o, cmd_ready_o, M_AXI_RVALID}); end
        n_cmp++; if ({r_n - rh0, rsp_n - r0} !== {32'd1, 32'd0}) begin n_bad++; $display("FAIL to_drain_counts: got r=%0d rsp=%0d want 1 0", r_n - rh0, rsp_n - r0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        int t [3];
        int a0, r0, k;
        addrs = '{32'h04, 32'h08, 32'h00};
        datas = '{32'h2, 32'h1F40_9C40, 32'h3};
        a0 = aw_log.size(); r0 = rsp_n; rsp_ready_i = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = addrs[i]; cmd_wdata_i = datas[i]; cmd_wstrb_i = 4'hF;
            k = 0;
            while (!cmd_ready_o && k < 20) begin @(negedge clk_i); k++; end
            n_cmp++; if (cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_accept%0d: got %b want 1", i, cmd_ready_o); end
            if (i > 0) begin
                n_cmp++; if ({M_AXI_BREADY, M_AXI_RREADY} !== 2'b00) begin n_bad++; $display("FAIL b2b_drain_gate%0d: got %b want 00", i, {M_AXI_BREADY, M_AXI_RREADY}); end
            end
            t[i] = cyc;
            @(negedge clk_i);
        end
        cmd_valid_i = 1'b0;
        k = 0;
        while (rsp_n - r0 < 3 && k < 20) begin @(negedge clk_i); k++; end
        rsp_ready_i = 1'b0;
        n_cmp++; if (rsp_n - r0 !== 3) begin n_bad++; $display("FAIL b2b_rsp_count: got %0d want 3", rsp_n - r0); end
        n_cmp++; if ({t[1] - t[0], t[2] - t[1]} !== {32'd4, 32'd4}) begin n_bad++; $display("FAIL b2b_spacing: got %0d %0d want 4 4", t[1] - t[0], t[2] - t[1]); end
        n_cmp++; if (aw_log.size() != a0 + 3 || aw_log[a0] !== 32'h04 || aw_log[a0+1] !== 32'h08 || aw_log[a0+2] !== 32'h00) begin n_bad++; $display("FAIL b2b_order: got %0d addresses want 4,8,0 in order", aw_log.size() - a0); end
        n_cmp++; if ({regs[1], regs[2], regs[0]} !== {32'h2, 32'h1F40_9C40, 32'h3}) begin n_bad++; $display("FAIL b2b_regs: got %h %h %h want 00000002 1f409c40 00000003", regs[1], regs[2], regs[0]); end
        n_cmp++; if (max_out !== 1) begin n_bad++; $display("FAIL b2b_outstanding: got %0d want 1", max_out); end
    endtask

    task automatic test_reset_mid();
        int r0, k;
        b_stall = 1'b1; r0 = rsp_n;
        issue(1'b1, 32'h14, 32'h0000_ABCD);
        @(negedge clk_i); cmd_valid_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (M_AXI_BREADY !== 1'b1) begin n_bad++; $display("FAIL rm_in_wr_resp: got %b want 1", M_AXI_BREADY); end
        resetn_i = 1'b0;
        #1;
        n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid_o, cmd_ready_o} !== 7'b0) begin n_bad++; $display("FAIL rm_async: got %b want 0000000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid_o, cmd_ready_o}); end
        @(negedge clk_i); resetn_i = 1'b1; b_stall = 1'b0;
        @(negedge clk_i);
        n_cmp++; if ({cmd_ready_o, rsp_valid_o, rsp_n - r0 == 0} !== 3'b101) begin n_bad++; $display("FAIL rm_idle: got %b want 101", {cmd_ready_o, rsp_valid_o, rsp_n - r0 == 0}); end
        issue(1'b1, 32'h14, 32'h0000_5A5A);
        @(negedge clk_i); cmd_valid_i = 1'b0;
        k = 0;
        while (!rsp_valid_o && k < 20) begin @(negedge clk_i); k++; end
        n_cmp++; if ({rsp_valid_o, rsp_write_o, rsp_resp_o, rsp_timeout_o} !== 5'b11000) begin n_bad++; $display("FAIL rm_next_rsp: got %b want 11000", {rsp_valid_o, rsp_write_o, rsp_resp_o, rsp_timeout_o}); end
        rsp_ready_i = 1'b1;
        @(negedge clk_i); rsp_ready_i = 1'b0;
        n_cmp++; if (regs[5] !== 32'h0000_5A5A) begin n_bad++; $display("FAIL rm_reg5: got %h want 00005a5a", regs[5]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_readback();
        test_skewed_write();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
